// File: rtl/uart_rx_frame_parser.sv
// Byte-level frame parser behind a UART receiver: hunts HEADER, collects a
// length-prefixed payload, verifies an 8-bit additive checksum and holds good frames.
module uart_rx_frame_parser #(
  parameter logic [7:0]  HEADER         = 8'hAA,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       frame_ready,
  output logic [4:0] frame_len,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       frame_ack,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic [7:0] drop_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;

  state_t        state_q;
  logic [4:0]    len_q;
  logic [3:0]    idx_q;
  logic [7:0]    sum_q;
  logic [TW-1:0] tmo_q;
  logic          frame_ready_q;
  logic [4:0]    frame_len_q;
  logic [7:0]    rd_data_q;
  logic          err_chk_q;
  logic          err_len_q;
  logic          err_tmo_q;
  logic [7:0]    drop_cnt_q;
  logic [7:0]    buf_mem [16];
  logic          buf_we;

  assign buf_we = !rst && (state_q == S_PAYLOAD) && rx_done;

  // NOTE: the payload buffer has no reset; its contents are only meaningful
  // while frame_ready is high, so clearing it would cost logic for nothing.
  always_ff @(posedge sysclk) begin
    if (buf_we) buf_mem[idx_q] <= rx_data;
  end

  // NOTE: every register here uses <= so all state updates see the values
  // from the start of the cycle, regardless of statement order.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q       <= S_HUNT;
      len_q         <= '0;
      idx_q         <= '0;
      sum_q         <= '0;
      tmo_q         <= '0;
      frame_ready_q <= 1'b0;
      frame_len_q   <= '0;
      rd_data_q     <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      rd_data_q <= buf_mem[rd_addr];

      case (state_q)
        S_HUNT: begin
          tmo_q <= '0;
          if (rx_done && rx_data == HEADER) state_q <= S_LEN;
        end

        S_LEN, S_PAYLOAD, S_CHK: begin
          if (rx_done) begin
            // A byte arriving on the timeout cycle keeps the frame alive.
            tmo_q <= '0;
            case (state_q)
              S_LEN: begin
                if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                  err_len_q <= 1'b1;
                  state_q   <= S_HUNT;
                end else begin
                  len_q   <= rx_data[4:0];
                  sum_q   <= rx_data;
                  idx_q   <= '0;
                  state_q <= S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                sum_q <= sum_q + rx_data;
                idx_q <= idx_q + 4'd1;
                if ({1'b0, idx_q} == len_q - 5'd1) state_q <= S_CHK;
              end
              default: begin
                if (rx_data == sum_q) begin
                  frame_ready_q <= 1'b1;
                  frame_len_q   <= len_q;
                  state_q       <= S_HOLD;
                end else begin
                  err_chk_q <= 1'b1;
                  state_q   <= S_HUNT;
                end
              end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            err_tmo_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= S_HUNT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_HOLD: begin
          tmo_q <= '0;
          if (rx_done && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
          if (frame_ack) begin
            frame_ready_q <= 1'b0;
            state_q       <= S_HUNT;
          end
        end

        default: state_q <= S_HUNT;
      endcase
    end
  end

  assign frame_ready = frame_ready_q;
  assign frame_len   = frame_len_q;
  assign rd_data     = rd_data_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_tmo_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: doc/uart_rx_frame_parser.md
# uart_rx_frame_parser

Byte-level frame parser sitting directly downstream of the UART receiver: consumes each received byte with its one-cycle done strobe, hunts for a header, collects a length-prefixed payload into a 16-byte buffer, and verifies an 8-bit additive checksum. Good frames are held for the host logic with a ready/ack handshake and random-access read port. Bad, truncated or stalled frames are discarded with error pulses.

## Interface
- HEADER, 8'hAA, start-of-frame byte
- MAX_LEN, 16, largest accepted payload length (1..16; buffer depth fixed at 16)
- TIMEOUT_CYCLES, 50000, sysclk cycles allowed between bytes inside a frame
- sysclk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from UART receiver, valid when rx_done=1
- rx_done  in  1  one-cycle strobe per received byte
- frame_ready  out  1  verified frame held in buffer
- frame_len  out  5  payload length of held frame (1..MAX_LEN)
- rd_addr  in  4  payload byte index to read
- rd_data  out  8  buffer[rd_addr], registered
- frame_ack  in  1  host releases held frame
- err_chk  out  1  one-cycle pulse: checksum mismatch
- err_len  out  1  one-cycle pulse: LEN byte 0 or > MAX_LEN
- err_timeout  out  1  one-cycle pulse: inter-byte timeout mid-frame
- drop_cnt  out  8  saturating count of bytes received while frame held

## Operation
- States: HUNT, LEN, PAYLOAD, CHK, HOLD. Transitions only on rx_done except HOLD exit and timeout.
- HUNT: rx_done && rx_data==HEADER -> LEN; any other byte ignored.
- LEN: rx_data==0 or >MAX_LEN -> err_len, HUNT (byte not re-examined as header). Else len<=rx_data, sum<=rx_data, idx<=0 -> PAYLOAD.
- PAYLOAD: buf[idx]<=rx_data, sum<=sum+rx_data (mod 256), idx<=idx+1; byte with idx==len-1 -> CHK.
- CHK: rx_data==sum -> HOLD, frame_len<=len; else err_chk, HUNT.
- HOLD: frame_ready=1; buffer not written. rx_done -> byte discarded, drop_cnt+1 (saturates at 255, cleared only by rst). frame_ack -> HUNT.
- frame_ack outside HOLD ignored.
- Checksum = low 8 bits of LEN + all payload bytes; header excluded.
- Timeout counter (width clog2(TIMEOUT_CYCLES+1)): cleared on every rx_done and in HUNT/HOLD; increments in LEN/PAYLOAD/CHK; reaching TIMEOUT_CYCLES -> err_timeout, HUNT, counter cleared.
- rd_data: every cycle rd_data<=buf[rd_addr]; content guaranteed only while frame_ready=1; rd_addr>=frame_len returns unspecified stale data.

## Timing
- Reset: state HUNT; frame_ready, frame_len, rd_data, err_chk, err_len, err_timeout, drop_cnt all 0; idx, sum, timeout counter 0; buffer contents not reset.
- rst mid-frame or in HOLD: frame abandoned, outputs return to reset values next cycle.
- frame_ready rises the cycle after the checksum byte's rx_done; falls the cycle after frame_ack.
- Error pulses assert the cycle after the offending rx_done (or timeout match), exactly one cycle wide.
- rd_data latency: 1 cycle from rd_addr.
- HOLD with frame_ack and rx_done same cycle: byte dropped and counted, state -> HUNT; byte not treated as header.
- Timeout match and rx_done same cycle: rx_done wins, no err_timeout.
- Back-to-back rx_done on consecutive cycles must be accepted.

## Test plan
- Bytes AA 03 01 02 03 09 -> frame_ready=1, frame_len=3; rd_addr 0,1,2 -> rd_data 01,02,03 one cycle later; frame_ack -> frame_ready=0 next cycle.
- Bytes AA 03 01 02 03 08 -> err_chk single pulse, frame_ready stays 0; following AA 01 55 56 accepted (frame_len=1, rd_data[0]=55).
- Bytes AA 00 and AA 11 (MAX_LEN=16) -> err_len pulse each, state HUNT; AA 10 + 16 bytes 01..10 + 98 -> accepted, frame_len=16.
- Checksum wrap: AA 02 FF 03 04 -> accepted; leading garbage 00 55 before AA ignored.
- AA 02 11 then silence TIMEOUT_CYCLES cycles -> err_timeout pulse, HUNT; next complete frame parsed normally.
- In HOLD send 300 bytes -> drop_cnt=255, buffer unchanged; frame_ack coincident with rx_data=AA -> dropped, next frame requires new AA; rst asserted mid-PAYLOAD -> all outputs 0.
